pipe_stage_ctrl: RTL

Central stall/flush sequencer for the 5-stage CPU pipeline. It generates the `enable` and synchronous flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB `flopenr` registers. It resolves load-use hazards, taken branches and multi-cycle data-memory accesses through a req/ack handshake, and traps a hung memory access with a timeout.

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/wait_timer.sv | 27 ++
 rtl/pipe_stage_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// enable/flush bundle and the decode used in RUN and on a memory ack.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } pipe_state_t;

  localparam int PIPE_TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic en_pc;
    logic en_fd;
    logic en_de;
    logic en_em;
    logic en_mw;
    logic flush_fd;
    logic flush_de;
  } pipe_en_t;

  // A taken branch squashes the ID instruction, so it outranks a load-use stall.
  function automatic pipe_en_t run_decode(input logic branch_taken,
                                          input logic ld_use_hazard);
    pipe_en_t c;
    c.en_pc    = 1'b1;
    c.en_fd    = 1'b1;
    c.en_de    = 1'b1;
    c.en_em    = 1'b1;
    c.en_mw    = 1'b1;
    c.flush_fd = 1'b0;
    c.flush_de = 1'b0;
    if (branch_taken) begin
      c.flush_fd = 1'b1;
      c.flush_de = 1'b1;
    end else if (ld_use_hazard) begin
      c.en_pc    = 1'b0;
      c.en_fd    = 1'b0;
      c.flush_de = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts MEM_WAIT cycles; expired flags that the count has reached the
// configured timeout.
module wait_timer #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Clear has priority so an ack always leaves the counter at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= CNT_W'(1);
    else if (inc)  count <= count + CNT_W'(1);
  end

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters enabled by defining PIPE_STALL_PERF_EN.
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PIPE_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_use_hazard,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        en_pc,
  output logic        en_fd,
  output logic        en_de,
  output logic        en_em,
  output logic        en_mw,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        mem_busy,
`ifdef PIPE_STALL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_events,
`endif
  output logic        mem_timeout
);

  pipe_state_t state, next_state;
  pipe_en_t    ctl;
  logic        busy, trapped;
  logic        tmr_load, tmr_inc, tmr_clr, tmr_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // Outputs depend on the live inputs so a stall freezes the same edge.
  always_comb begin
    next_state = state;
    ctl        = '0;
    busy       = 1'b0;
    trapped    = 1'b0;
    tmr_load   = 1'b0;
    tmr_inc    = 1'b0;
    tmr_clr    = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ack) begin
          next_state = MEM_WAIT;
          tmr_load   = 1'b1;
        end else begin
          ctl = run_decode(branch_taken, ld_use_hazard);
        end
      end
      MEM_WAIT: begin
        busy = 1'b1;
        if (mem_ack) begin
          ctl        = run_decode(branch_taken, ld_use_hazard);
          next_state = RUN;
          tmr_clr    = 1'b1;
        end else if (tmr_expired) begin
          next_state = TRAP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      TRAP: begin
        trapped = 1'b1;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  wait_timer #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .inc     (tmr_inc),
    .clr     (tmr_clr),
    .expired (tmr_expired)
  );

  // Reset forces every control low regardless of the combinational decode.
  assign en_pc       = ctl.en_pc    & ~reset;
  assign en_fd       = ctl.en_fd    & ~reset;
  assign en_de       = ctl.en_de    & ~reset;
  assign en_em       = ctl.en_em    & ~reset;
  assign en_mw       = ctl.en_mw    & ~reset;
  assign flush_fd    = ctl.flush_fd & ~reset;
  assign flush_de    = ctl.flush_de & ~reset;
  assign mem_busy    = busy         & ~reset;
  assign mem_timeout = trapped      & ~reset;

`ifdef PIPE_STALL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (state != TRAP && !ctl.en_pc && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (ctl.flush_fd || ctl.flush_de)
        flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule
